// File: rtl/alu16_mul_seq.sv
// rtl/alu16_mul_seq.sv - 16x16 low-half multiply sequencer that borrows the shared ALU
module alu16_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        seq_busy,
    input  logic [15:0] dp_a,
    input  logic [15:0] dp_b,
    input  logic [3:0]  dp_shamt,
    input  logic [2:0]  dp_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_shamt,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_out
);
    typedef enum logic [2:0] {IDLE, SCAN, SHIFT, ADD, RESP} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b111;

    state_t      state;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [15:0] acc;
    logic [15:0] tmp;
    logic [3:0]  i;

    assign rsp_data = acc;

    // Status flags are registered alongside each state transition so they
    // always agree with the state the sequencer is in during the cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            tmp       <= '0;
            i         <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            seq_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a_reg     <= req_a;
                        b_reg     <= req_b;
                        acc       <= '0;
                        i         <= '0;
                        state     <= SCAN;
                        req_ready <= 1'b0;
                        seq_busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (b_reg[i]) begin
                        state <= SHIFT;
                    end else if (i == 4'd15) begin
                        state     <= RESP;
                        seq_busy  <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        i <= i + 4'd1;
                    end
                end
                SHIFT: begin
                    tmp   <= alu_out;
                    state <= ADD;
                end
                ADD: begin
                    acc <= alu_out;
                    if (i == 4'd15) begin
                        state     <= RESP;
                        seq_busy  <= 1'b0;
                        rsp_valid <= 1'b1;
                    end else begin
                        i     <= i + 4'd1;
                        state <= SCAN;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    seq_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The datapath keeps the ALU whenever the sequencer is not busy, RESP included.
    always_comb begin
        alu_a     = dp_a;
        alu_b     = dp_b;
        alu_shamt = dp_shamt;
        alu_op    = dp_op;
        if (seq_busy) begin
            case (state)
                SHIFT: begin
                    alu_a     = acc;
                    alu_b     = a_reg;
                    alu_shamt = i;
                    alu_op    = OP_SLL;
                end
                ADD: begin
                    alu_a     = acc;
                    alu_b     = tmp;
                    alu_shamt = 4'd0;
                    alu_op    = OP_ADD;
                end
                default: begin
                    alu_a     = acc;
                    alu_b     = 16'd0;
                    alu_shamt = 4'd0;
                    alu_op    = OP_ADD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu16_mul_seq.sv
// tb/tb_alu16_mul_seq.sv - directed bench with a cycle-level behavioural model of the multiply sequencer
module tb_alu16_mul_seq;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        seq_busy;
    logic [15:0] dp_a = '0;
    logic [15:0] dp_b = '0;
    logic [3:0]  dp_shamt = '0;
    logic [2:0]  dp_op = '0;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_shamt;
    logic [2:0]  alu_op;
    logic [15:0] alu_out;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    alu16_mul_seq dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .seq_busy(seq_busy),
        .dp_a(dp_a), .dp_b(dp_b), .dp_shamt(dp_shamt), .dp_op(dp_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_op(alu_op),
        .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    // The shared combinational ALU the sequencer drives
    always_comb begin
        alu_out = 16'h0000;
        if (alu_op == 3'b000)      alu_out = alu_a + alu_b;
        else if (alu_op == 3'b111) alu_out = alu_b << alu_shamt;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a request occupies the ALU for 16 + 2*popcount(b) cycles, then the
    // truncated product is offered until taken, then one idle cycle.
    bit          m_idle = 1'b1;
    bit          m_resp = 1'b0;
    int          m_busy_left = 0;
    logic [15:0] m_prod = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_idle = 1'b1; m_resp = 1'b0; m_busy_left = 0;
        end else if (m_idle && req_valid) begin
            m_idle = 1'b0;
            m_busy_left = 16 + 2 * $countones(req_b);
            m_prod = 16'((32'(req_a) * 32'(req_b)) & 32'hFFFF);
        end else if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) m_resp = 1'b1;
        end else if (m_resp && rsp_ready) begin
            m_resp = 1'b0;
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_req_ready", req_ready, m_idle);
            chk("m_seq_busy", seq_busy, m_busy_left > 0);
            chk("m_rsp_valid", rsp_valid, m_resp);
            if (m_resp) chk("m_rsp_data", rsp_data, m_prod);
            if (m_busy_left == 0) begin
                chk("m_byp_a", alu_a, dp_a);
                chk("m_byp_b", alu_b, dp_b);
                chk("m_byp_shamt", alu_shamt, dp_shamt);
                chk("m_byp_op", alu_op, dp_op);
            end
        end
    end

    // Issue one multiply and follow it to the handshake; request is held
    // high through the sequence, which the block must ignore.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp, input int lat, input int hold);
        int cnt;
        int busy_cnt;
        bit saw_sll;
        @(negedge clk);
        chk("pre_req_ready", req_ready, 1'b1);
        #1 req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = (hold == 0);
        @(negedge clk);
        cnt = 1; busy_cnt = 0; saw_sll = 1'b0;
        while (!rsp_valid && cnt < 80) begin
            if (seq_busy) busy_cnt++;
            if (seq_busy && alu_op == 3'b111) saw_sll = 1'b1;
            if (seq_busy && b == 16'h0000) begin
                chk("scan_alu_a", alu_a, 16'h0000);
                chk("scan_alu_b", alu_b, 16'h0000);
            end
            @(negedge clk);
            cnt++;
        end
        chk("rsp_valid_seen", rsp_valid, 1'b1);
        chk("latency", cnt, lat);
        chk("busy_cycles", busy_cnt, lat - 1);
        chk("rsp_data", rsp_data, exp);
        if (b == 16'h0000) chk("no_sll_for_zero", saw_sll, 1'b0);
        for (int k = 0; k < hold; k++) begin
            #1 req_valid = ~req_valid;
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1'b1);
            chk("hold_data", rsp_data, exp);
            chk("hold_not_ready", req_ready, 1'b0);
        end
        #1 rsp_ready = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        chk("post_rsp_valid", rsp_valid, 1'b0);
        chk("post_req_ready", req_ready, 1'b1);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        cmp_en = 1'b1;
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 16'h0000);
        chk("rst_busy", seq_busy, 1'b0);
        #1 reset = 1'b0;
        dp_a = 16'd7; dp_b = 16'd9; dp_op = 3'b000; dp_shamt = 4'd2;
        @(negedge clk);
        chk("byp_a", alu_a, 16'd7);
        chk("byp_b", alu_b, 16'd9);
        chk("byp_op", alu_op, 3'b000);
        chk("byp_out", alu_out, 16'd16);

        run_mul(16'd3, 16'd5, 16'h000F, 21, 0);
        #1 dp_a = 16'h5555; dp_b = 16'hAAAA; dp_op = 3'b011;
        run_mul(16'h1234, 16'h0000, 16'h0000, 17, 0);
        run_mul(16'hFFFF, 16'hFFFF, 16'h0001, 49, 0);
        run_mul(16'h0100, 16'h0100, 16'h0000, 19, 0);
        run_mul(16'h00AB, 16'h0013, 16'h0CB1, 23, 10);

        // Abandon a multiply while it is in SHIFT
        @(negedge clk);
        #1 req_a = 16'd7; req_b = 16'h00F0; req_valid = 1'b1;
        @(negedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!(seq_busy && alu_op == 3'b111) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("reach_shift", seq_busy && alu_op == 3'b111, 1'b1);
        chk("shift_shamt", alu_shamt, 4'd4);
        chk("shift_b", alu_b, 16'd7);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_rsp_data", rsp_data, 16'h0000);
        chk("abort_busy", seq_busy, 1'b0);
        #1 reset = 1'b0;
        run_mul(16'd2, 16'd3, 16'h0006, 21, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu16_mul_seq.md
# alu16_mul_seq

Multi-cycle sequencer that computes a 16×16 multiply (low 16 bits of product) by driving the existing combinational 16-bit ALU through shift-left and add operations, one multiplier bit at a time. It sits beside the ALU as its owner-of-record. While idle it passes the main datapath's ALU controls straight through. While sequencing it takes the ALU over and raises a busy flag so the single-cycle core stalls.

## Interface
- No parameters (width fixed at 16, bit counter 4 bits).
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  multiply request
- req_ready  out  1  sequencer can accept a request
- req_a  in  16  multiplicand
- req_b  in  16  multiplier
- rsp_valid  out  1  product available
- rsp_ready  in  1  consumer takes product
- rsp_data  out  16  product[15:0]
- seq_busy  out  1  sequencer owns the ALU; core must stall
- dp_a, dp_b  in  16  datapath ALU operands (bypass)
- dp_shamt  in  4  datapath shift amount
- dp_op  in  3  datapath ALU select {s2,s1,s0}
- alu_a, alu_b  out  16  to ALU a, b
- alu_shamt  out  4  to ALU shamt
- alu_op  out  3  to ALU {s2,s1,s0}
- alu_out  in  16  ALU result (combinational, same cycle)

## Operation
- ALU select codes: 000 ADD (a+b), 111 SLL (b<<shamt). Other codes are not issued by the sequencer.
- States: IDLE, SCAN, SHIFT, ADD, RESP.
- IDLE:
  - req_ready=1. On req_valid: latch A=req_a and B=req_b, set acc=0 and i=0, go to SCAN.
- SCAN:
  - Examine B[i].
  - If B[i]=1, go to SHIFT.
  - Else, if i=15 go to RESP; otherwise i←i+1 and stay in SCAN.
  - ALU drive: a=acc, b=0, shamt=0, op=000 (benign).
- SHIFT:
  - ALU drive: a=acc, b=A, shamt=i, op=111. Latch tmp←alu_out.
  - Go to ADD.
- ADD:
  - ALU drive: a=acc, b=tmp, shamt=0, op=000. Latch acc←alu_out.
  - If i=15 go to RESP; otherwise i←i+1 and go to SCAN.
- RESP:
  - rsp_valid=1 and rsp_data=acc, both held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
- Output bypass:
  - When seq_busy=0, alu_a/alu_b/alu_shamt/alu_op equal dp_a/dp_b/dp_shamt/dp_op combinationally.
  - When seq_busy=1, the sequencer drives them per state.
- seq_busy=1 in SCAN, SHIFT and ADD; 0 in IDLE and RESP.
- Arithmetic: modulo 2^16, carries discarded. Product bits 31:16 are dropped; the signed and unsigned low halves are identical.

## Timing
- Reset values: state=IDLE, acc=0, tmp=0, i=0, rsp_valid=0, rsp_data=0, seq_busy=0, req_ready=1 (the first cycle after reset deasserts).
- Accept cycle T: the request is captured on the edge that ends T. The first SCAN occurs at T+1.
- Latency: rsp_valid first rises at cycle T+17+2·popcount(req_b). This is deterministic, with no early exit on zero upper bits.
- req_ready=1 only in IDLE. req_valid in any other state is ignored and not queued.
- After the response handshake there is one idle cycle: req_ready rises in the cycle after rsp_valid&&rsp_ready. No request is accepted in the same cycle as response consumption.
- rsp_ready held 0: remain in RESP indefinitely, with rsp_data unchanged and seq_busy=0 (the datapath may use the ALU).
- Reset asserted in any state: the operation is abandoned, no response is issued, and the block returns to reset values on the next edge.
- seq_busy is registered from state. The core sees the stall in the same cycle the sequencer begins driving the ALU.

## Test plan
- Reset, then req_a=3, req_b=5 with rsp_ready=1 → rsp_data=0x000F; rsp_valid at T+21; seq_busy high for exactly 20 cycles.
- req_a=0x1234, req_b=0 → rsp_data=0x0000 at T+17. No SHIFT or ADD cycles occur (alu_op never 111 while busy).
- req_a=0xFFFF, req_b=0xFFFF → rsp_data=0x0001 at T+49. Also 0x0100×0x0100 → 0x0000 (wrap).
- Bypass: in IDLE drive dp_a=7, dp_b=9, dp_op=000 → alu_a=7, alu_b=9, alu_op=000. Mid-sequence, alu_* ignore dp_* changes.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid/rsp_data stable and req_valid pulses are ignored. Raise rsp_ready → one handshake, then req_ready=1 the next cycle.
- Reset during SHIFT of 7×0x00F0 → no rsp_valid, all outputs at reset values. A new request 2×3 afterward → 0x0006.
